// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
package bus_arbiter_pkg;

    localparam int N_REQ_C = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [N_REQ_C-1:0] onehot(input sel_t idx);
        logic [N_REQ_C-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating priority encoder: first set, non-excluded request at or after start.
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [N_REQ_C-1:0] req,
    input  sel_t               start,
    input  logic [N_REQ_C-1:0] exclude,
    output logic               found,
    output sel_t               idx
);

    logic [N_REQ_C-1:0] w_masked;
    logic [N_REQ_C-1:0] w_rot;

    assign w_masked = req & ~exclude;

    // w_rot[k] is the request k positions after start, so bit 0 has top priority.
    for (genvar gi = 0; gi < N_REQ_C; gi++) begin : g_rot
        assign w_rot[gi] = w_masked[sel_t'(start + sel_t'(gi))];
    end

    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = N_REQ_C - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                idx   = sel_t'(start + sel_t'(k));
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving the 8-way bus select; define
// BUS_ARBITER_BURST_LIMIT_EN to force a handoff after MAX_BURST cycles.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_REQ     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       sel,
    output logic             sel_valid,
    output logic             busy
);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [N_REQ_C-1:0]  r_gnt;
    logic [N_REQ_C-1:0]  w_gnt_next;
    sel_t                r_sel;
    sel_t                w_sel_next;
    sel_t                r_last;
    sel_t                w_last_next;
    logic                w_take;

    sel_t                w_start;
    logic [N_REQ_C-1:0]  w_exclude;
    logic                w_found;
    sel_t                w_idx;

    if (MAX_BURST < 2) begin : g_bad_burst
    end

    // While granted, last == sel, so one search origin serves both states.
    assign w_start   = sel_t'(r_last + sel_t'(1));
    assign w_exclude = (r_state == GRANT) ? onehot(r_sel) : '0;

    rr_pick u_pick (
        .req     (req),
        .start   (w_start),
        .exclude (w_exclude),
        .found   (w_found),
        .idx     (w_idx)
    );

`ifdef BUS_ARBITER_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_burst_done;

    assign w_burst_done = (r_cnt == CNT_MAX);

    // Counter only runs while the owner keeps holding; every other case restarts it.
    always_comb begin
        w_cnt_next = '0;
        if (r_state == GRANT && req[r_sel] && !w_burst_done) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_last_next  = r_last;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take       = 1'b1;
                    w_state_next = GRANT;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    if (w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                        w_gnt_next   = '0;
                    end
                end
`ifdef BUS_ARBITER_BURST_LIMIT_EN
                else if (w_burst_done && w_found) begin
                    w_take = 1'b1;
                end
`endif
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = '0;
            end
        endcase
        if (w_take) begin
            w_gnt_next  = onehot(w_idx);
            w_sel_next  = w_idx;
            w_last_next = w_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_last  <= sel_t'(N_REQ_C - 1);
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_last  <= w_last_next;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign sel_valid = |r_gnt;
    assign busy      = (r_state == GRANT);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus reset, hold and burst sequences.
module tb_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[18];

    bus_arbiter #(.N_REQ(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " gnt"}, 32'(gnt), 32'(e.gnt));
            chk({tag, " sel"}, 32'(sel), 32'(e.sel));
            chk({tag, " busy"}, 32'(busy), 32'(e.busy));
            chk({tag, " sel_valid"}, 32'(sel_valid), 32'(e.gnt != 8'h00));
        end
        $display("txn %s: req=%02h gnt=%02h sel=%0d busy=%0b", tag, req, gnt, sel, busy);
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] es,
                         input logic eb, input string tag);
        exp_t e;
        @(negedge clk);
        req = r;
        e.gnt = eg; e.sel = es; e.busy = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 32'h0);
        chk({tag, " sel"}, 32'(sel), 32'h0);
        chk({tag, " sel_valid"}, 32'(sel_valid), 32'h0);
        chk({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    // Release reset at a falling edge and check the grant produced at the next rising edge.
    task automatic release_reset(input logic [7:0] eg, input logic [2:0] es, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        e.gnt = eg; e.sel = es; e.busy = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic async_reset(input logic [7:0] r);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = r;
        #1;
    endtask

    initial begin
        vecs[0]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{8'h20, 8'h20, 3'd5, 1'b1};
        vecs[2]  = '{8'h20, 8'h20, 3'd5, 1'b1};
        vecs[3]  = '{8'h00, 8'h00, 3'd5, 1'b0};
        vecs[4]  = '{8'h44, 8'h40, 3'd6, 1'b1};
        vecs[5]  = '{8'h44, 8'h40, 3'd6, 1'b1};
        vecs[6]  = '{8'h06, 8'h02, 3'd1, 1'b1};
        vecs[7]  = '{8'h06, 8'h02, 3'd1, 1'b1};
        vecs[8]  = '{8'h44, 8'h04, 3'd2, 1'b1};
        vecs[9]  = '{8'h46, 8'h04, 3'd2, 1'b1};
        vecs[10] = '{8'h42, 8'h40, 3'd6, 1'b1};
        vecs[11] = '{8'h41, 8'h40, 3'd6, 1'b1};
        vecs[12] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[13] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vecs[14] = '{8'h80, 8'h80, 3'd7, 1'b1};
        vecs[15] = '{8'h81, 8'h80, 3'd7, 1'b1};
        vecs[16] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vecs[17] = '{8'h00, 8'h00, 3'd0, 1'b0};

        rst_n = 1'b0;
        req   = 8'hFF;
        #1;
        chk_cleared("reset t0");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk_cleared($sformatf("reset edge%0d", c));
        end
        release_reset(8'h01, 3'd0, "reset release");

        for (int v = 0; v < 18; v++) begin
            drive(vecs[v].req, vecs[v].gnt, vecs[v].sel, vecs[v].busy, $sformatf("vec%0d", v));
        end

        for (int c = 0; c < 10; c++) begin
            drive(8'h20, 8'h20, 3'd5, 1'b1, $sformatf("single%0d", c));
        end
        drive(8'h00, 8'h00, 3'd5, 1'b0, "single drop");

        drive(8'h20, 8'h20, 3'd5, 1'b1, "pre-async a");
        drive(8'h20, 8'h20, 3'd5, 1'b1, "pre-async b");
        async_reset(8'h60);
        chk_cleared("async mid-grant");
        release_reset(8'h20, 3'd5, "async resume");
        drive(8'h00, 8'h00, 3'd5, 1'b0, "async drop");

        async_reset(8'h00);
        chk_cleared("async idle");
`ifdef BUS_ARBITER_BURST_LIMIT_EN
        req = 8'hFF;
        release_reset(8'h01, 3'd0, "burst first");
        for (int c = 1; c < 36; c++) begin
            logic [2:0] s;
            s = 3'((c / 4) % 8);
            drive(8'hFF, 8'h01 << s, s, 1'b1, $sformatf("burst%0d", c));
        end
`else
        req = 8'h09;
        release_reset(8'h01, 3'd0, "hold first");
        for (int c = 1; c < 100; c++) begin
            drive(8'h09, 8'h01, 3'd0, 1'b1, $sformatf("hold%0d", c));
        end
`endif
        drive(8'h00, 8'h00, 3'd0, 1'b0, "final drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
